rs_station: RTL and testbench
=============================

RS_STATION -- requirements
Module: rs_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8: number of entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_W, default 4: ROB tag width; tag 0 means "no dependency", so valid ROB tags are 1..2^ROB_W-1.
REQ-003 SHALL have ports:
  clk  in  1  clock, rising edge.
  rst  in  1  asynchronous, active-low reset.
  rdy  in  1  global enable; state frozen when 0.
  clear  in  1  misprediction flush.
  is_rs  in  1  issue valid.
  op  in  6  decoded operation.
  Vj, Vk  in  32  operand values.
  Qj, Qk  in  ROB_W  operand tags.
  imm, pc  in  32  immediate and PC.
  entry  in  ROB_W  destination ROB tag.
  full  out  1  all entries busy.
  cdb_alu_valid  in  1  ALU broadcast valid.
  cdb_alu_tag  in  ROB_W  ALU broadcast tag.
  cdb_alu_val  in  32  ALU broadcast value.
  cdb_lsb_valid  in  1  LSB broadcast valid.
  cdb_lsb_tag  in  ROB_W  LSB broadcast tag.
  cdb_lsb_val  in  32  LSB broadcast value.
  alu_valid  out  1  dispatch valid (registered).
  alu_op  out  6  registered dispatch field.
  alu_a, alu_b, alu_imm, alu_pc  out  32  registered dispatch fields.
  alu_tag  out  ROB_W  registered dispatch field.

Function
REQ-004 Each entry SHALL hold busy, op, Vj, Vk, Qj, Qk, imm, pc and tag; an operand is ready when its Q is 0.
REQ-005 full SHALL be combinational: 1 iff every entry is busy at that cycle's start. Upstream never asserts is_rs while full=1; is_rs with full=1 SHALL be ignored.
REQ-006 On an edge with rdy=1, is_rs=1 and full=0, the lowest-index entry free at cycle start SHALL be written with busy=1. An entry freed by dispatch in the same cycle SHALL NOT be reused that cycle.
REQ-007 Issue forwarding: if an incoming Qj or Qk is nonzero and equals a valid CDB tag in the same cycle, the entry SHALL store that CDB value and set the tag to 0.
REQ-008 Wake-up: for each busy entry with Qx != 0 matching a valid CDB tag, Vx SHALL take the CDB value and Qx SHALL become 0 at the edge. When both CDBs carry the same tag, the ALU CDB wins.
REQ-009 Dispatch: on each edge with rdy=1, one busy entry with Qj=0 and Qk=0 (state at cycle start) SHALL be selected. Its fields are registered onto alu_*, alu_valid=1, and the entry is freed. With no candidate, alu_valid=0 and the other alu_* outputs hold.
REQ-010 Latency: an instruction issued at edge k with ready operands into an otherwise idle station SHALL show alu_valid=1 after edge k+1. An entry woken at edge k SHALL be dispatchable at edge k+1 at the earliest.
REQ-011 Issue, wake-up and dispatch SHALL occur together in one cycle without interfering; there is at most one issue and one dispatch per edge.
REQ-012 While rdy=0, all entries and outputs SHALL hold; CDB and issue inputs are ignored.
REQ-013 clear=1 at an edge SHALL, irrespective of rdy, free all entries and force alu_valid=0. It has priority over issue, wake-up and dispatch.

Reset
REQ-014 While rst=0, all busy bits SHALL be 0, alu_valid=0, all other alu_* outputs 0, and full=0.
REQ-015 Reset SHALL act asynchronously mid-operation. The first issue SHALL be accepted at the first rising edge after rst returns to 1.

Configuration
REQ-016 With macro RS_OLDEST_FIRST_EN defined, dispatch SHALL pick the ready entry issued earliest, with age tracking surviving wrap-around and reuse. Undefined, dispatch SHALL pick the lowest-index ready entry. Ports are identical in both builds.

Verification
REQ-017 Ready issue: op=1, Vj=5, Vk=7, Qj=Qk=0, entry=3 at edge 1 -> after edge 2 alu_valid=1, alu_a=5, alu_b=7, alu_tag=3; after edge 3 alu_valid=0.
REQ-018 Wake-up: issue Qj=2, Vk=9 -> no dispatch; cdb_lsb_valid=1, tag=2, val=0x10 -> dispatch one edge later with alu_a=0x10. Same tag on both CDBs (ALU val=0x20) -> alu_a=0x20.
REQ-019 Issue forwarding: issue Qk=4 while cdb_alu_valid=1, tag=4, val=0xAB -> next edge dispatches with alu_b=0xAB.
REQ-020 Full: fill 8 blocked entries (Qj=1) -> full=1 and 9th is_rs ignored. Broadcast tag 1 -> 8 dispatches on consecutive edges, full=0 after first. Lowest-index order without RS_OLDEST_FIRST_EN; issue order with it, after slot reuse.
REQ-021 clear with 3 busy entries plus rdy=0 -> all freed, alu_valid=0. Async rst mid-dispatch -> outputs zero immediately, no edge required.

Source files
------------

// File: rtl/rs_station.sv
// Reservation station: CDB wake-up, issue-time forwarding, one issue and one dispatch per edge.
// Build option RS_OLDEST_FIRST_EN switches dispatch from lowest-index-ready to oldest-ready.
module rs_station #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             is_rs,
  input  logic [5:0]       op,
  input  logic [31:0]      Vj,
  input  logic [31:0]      Vk,
  input  logic [ROB_W-1:0] Qj,
  input  logic [ROB_W-1:0] Qk,
  input  logic [31:0]      imm,
  input  logic [31:0]      pc,
  input  logic [ROB_W-1:0] entry,
  output logic             full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_tag,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_tag,
  input  logic [31:0]      cdb_lsb_val,
  output logic             alu_valid,
  output logic [5:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam logic [ROB_W-1:0] NO_DEP = {ROB_W{1'b0}};

  typedef logic [ROB_W+31:0] opnd_t;  // {tag, value}

  // A pending operand captures a matching broadcast; the ALU bus wins a same-tag tie.
  function automatic opnd_t snoop(
    input logic [ROB_W-1:0] q,   input logic [31:0] v,
    input logic             av,  input logic [ROB_W-1:0] at, input logic [31:0] aval,
    input logic             lv,  input logic [ROB_W-1:0] lt, input logic [31:0] lval
  );
    opnd_t res;
    if ((q != NO_DEP) && av && (q == at)) begin
      res = {NO_DEP, aval};
    end else if ((q != NO_DEP) && lv && (q == lt)) begin
      res = {NO_DEP, lval};
    end else begin
      res = {q, v};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [RS_SIZE-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  logic [RS_SIZE-1:0] busy_r;
  logic [5:0]         op_r  [RS_SIZE];
  logic [31:0]        vj_r  [RS_SIZE];
  logic [31:0]        vk_r  [RS_SIZE];
  logic [31:0]        imm_r [RS_SIZE];
  logic [31:0]        pc_r  [RS_SIZE];
  logic [ROB_W-1:0]   qj_r  [RS_SIZE];
  logic [ROB_W-1:0]   qk_r  [RS_SIZE];
  logic [ROB_W-1:0]   tag_r [RS_SIZE];

  logic [RS_SIZE-1:0] ready_s;
  logic [RS_SIZE-1:0] pick_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   disp_idx_s;
  logic               issue_s;
  logic               disp_s;
  opnd_t              in_j_s;
  opnd_t              in_k_s;
  opnd_t              wake_j_s [RS_SIZE];
  opnd_t              wake_k_s [RS_SIZE];

`ifdef RS_OLDEST_FIRST_EN
  // older_r[i][j] = 1 when entry i was issued before entry j (meaningful among busy entries).
  logic [RS_SIZE-1:0] older_r [RS_SIZE];
`endif

  assign full = &busy_r;

  // Candidate selection, free-slot search and operand snooping, all from cycle-start state.
  always_comb begin
    ready_s = {RS_SIZE{1'b0}};
    pick_s  = {RS_SIZE{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_s[i]  = busy_r[i] && (qj_r[i] == NO_DEP) && (qk_r[i] == NO_DEP);
      wake_j_s[i] = snoop(qj_r[i], vj_r[i], cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                          cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
      wake_k_s[i] = snoop(qk_r[i], vk_r[i], cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                          cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    end
`ifdef RS_OLDEST_FIRST_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      pick_s[i] = ready_s[i] && (&(older_r[i] | ~ready_s | (RS_SIZE'(1'b1) << i)));
    end
`else
    pick_s = ready_s;
`endif
    free_idx_s = lowest_set(~busy_r);
    disp_idx_s = lowest_set(pick_s);
    issue_s    = is_rs && !full;
    disp_s     = |pick_s;
    in_j_s     = snoop(Qj, Vj, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                       cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    in_k_s     = snoop(Qk, Vk, cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                       cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
  end

  // Entry array and dispatch register; flush beats everything, rdy=0 freezes all state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {RS_SIZE{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        op_r[i]  <= 6'd0;
        vj_r[i]  <= 32'd0;
        vk_r[i]  <= 32'd0;
        imm_r[i] <= 32'd0;
        pc_r[i]  <= 32'd0;
        qj_r[i]  <= NO_DEP;
        qk_r[i]  <= NO_DEP;
        tag_r[i] <= NO_DEP;
      end
      alu_valid <= 1'b0;
      alu_op    <= 6'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_imm   <= 32'd0;
      alu_pc    <= 32'd0;
      alu_tag   <= NO_DEP;
    end else if (clear) begin
      busy_r    <= {RS_SIZE{1'b0}};
      alu_valid <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_r[i]) begin
          {qj_r[i], vj_r[i]} <= wake_j_s[i];
          {qk_r[i], vk_r[i]} <= wake_k_s[i];
        end
      end
      if (disp_s) begin
        busy_r[disp_idx_s] <= 1'b0;
        alu_valid <= 1'b1;
        alu_op    <= op_r[disp_idx_s];
        alu_a     <= vj_r[disp_idx_s];
        alu_b     <= vk_r[disp_idx_s];
        alu_imm   <= imm_r[disp_idx_s];
        alu_pc    <= pc_r[disp_idx_s];
        alu_tag   <= tag_r[disp_idx_s];
      end else begin
        alu_valid <= 1'b0;
      end
      // The free slot was free at cycle start, so it never collides with wake-up or dispatch.
      if (issue_s) begin
        busy_r[free_idx_s] <= 1'b1;
        op_r[free_idx_s]   <= op;
        imm_r[free_idx_s]  <= imm;
        pc_r[free_idx_s]   <= pc;
        tag_r[free_idx_s]  <= entry;
        {qj_r[free_idx_s], vj_r[free_idx_s]} <= in_j_s;
        {qk_r[free_idx_s], vk_r[free_idx_s]} <= in_k_s;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Age matrix update: a newly issued entry becomes younger than every other entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        older_r[i] <= {RS_SIZE{1'b0}};
      end
    end else if (!clear && rdy && issue_s) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        older_r[j][free_idx_s] <= (IDX_W'(j) != free_idx_s);
      end
      older_r[free_idx_s] <= {RS_SIZE{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_rs_station.sv
// Scoreboard bench for rs_station: an entry-list reference model predicts every dispatch,
// a separate monitor compares each DUT dispatch against the predicted queue.
module tb_rs_station;
  localparam int RS = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          clear = 1'b0;
  logic          is_rs = 1'b0;
  logic [5:0]    op = 6'd0;
  logic [31:0]   Vj = 32'd0, Vk = 32'd0, imm = 32'd0, pc = 32'd0;
  logic [RW-1:0] Qj = 4'd0, Qk = 4'd0, entry = 4'd0;
  logic          full;
  logic          cdb_alu_valid = 1'b0, cdb_lsb_valid = 1'b0;
  logic [RW-1:0] cdb_alu_tag = 4'd0, cdb_lsb_tag = 4'd0;
  logic [31:0]   cdb_alu_val = 32'd0, cdb_lsb_val = 32'd0;
  logic          alu_valid;
  logic [5:0]    alu_op;
  logic [31:0]   alu_a, alu_b, alu_imm, alu_pc;
  logic [RW-1:0] alu_tag;

  rs_station #(.RS_SIZE(RS), .ROB_W(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .is_rs(is_rs), .op(op),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .imm(imm), .pc(pc), .entry(entry), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_tag(alu_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy; logic [5:0] op; logic [31:0] vj, vk, imm, pc;
    logic [RW-1:0] qj, qk, tag; int seq;
  } ent_t;
  typedef struct {
    int stamp; logic [5:0] op; logic [31:0] a, b, imm, pc; logic [RW-1:0] tag;
  } disp_t;

  ent_t  m [RS];
  disp_t exp_q [$];
  disp_t last_out;
  disp_t mon_d;
  bit    last_valid;
  bit    oldest_first;
  int    seq_cnt = 0;
  int    edge_cnt = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW+31:0] bcast(input logic [RW-1:0] q, input logic [31:0] v);
    if (q == 4'd0) return {q, v};
    if (cdb_alu_valid && q == cdb_alu_tag) return {4'd0, cdb_alu_val};
    if (cdb_lsb_valid && q == cdb_lsb_tag) return {4'd0, cdb_lsb_val};
    return {q, v};
  endfunction

  function automatic void model_reset();
    foreach (m[i]) m[i].busy = 1'b0;
    last_valid = 1'b0;
    exp_q.delete();
  endfunction

  // Predicts the effect of the coming edge on the entry list and the dispatch output.
  function automatic void model_edge(input int stamp);
    int pick, fr;
    logic [RW+31:0] r;
    if (clear) begin
      foreach (m[i]) m[i].busy = 1'b0;
      last_valid = 1'b0;
      return;
    end
    if (!rdy) begin
      if (last_valid) begin
        last_out.stamp = stamp;
        exp_q.push_back(last_out);
      end
      return;
    end
    pick = -1;
    fr = -1;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy && m[i].qj == 4'd0 && m[i].qk == 4'd0 &&
          (pick < 0 || (oldest_first && m[i].seq < m[pick].seq))) pick = i;
      if (!m[i].busy && fr < 0) fr = i;
    end
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy) begin
        r = bcast(m[i].qj, m[i].vj); m[i].qj = r[RW+31:32]; m[i].vj = r[31:0];
        r = bcast(m[i].qk, m[i].vk); m[i].qk = r[RW+31:32]; m[i].vk = r[31:0];
      end
    end
    if (pick >= 0) begin
      last_out.stamp = stamp;       last_out.op = m[pick].op;
      last_out.a = m[pick].vj;      last_out.b = m[pick].vk;
      last_out.imm = m[pick].imm;   last_out.pc = m[pick].pc;
      last_out.tag = m[pick].tag;
      exp_q.push_back(last_out);
      m[pick].busy = 1'b0;
      last_valid = 1'b1;
    end else begin
      last_valid = 1'b0;
    end
    if (is_rs && fr >= 0) begin
      m[fr].busy = 1'b1; m[fr].op = op; m[fr].imm = imm; m[fr].pc = pc; m[fr].tag = entry;
      r = bcast(Qj, Vj); m[fr].qj = r[RW+31:32]; m[fr].vj = r[31:0];
      r = bcast(Qk, Vk); m[fr].qk = r[RW+31:32]; m[fr].vk = r[31:0];
      m[fr].seq = seq_cnt;
      seq_cnt++;
    end
  endfunction

  task automatic idle();
    is_rs = 1'b0; clear = 1'b0; rdy = 1'b1;
    cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
  endtask

  task automatic set_issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [RW-1:0] j, input logic [RW-1:0] k, input logic [RW-1:0] t);
    is_rs = 1'b1; op = o; Vj = a; Vk = b; Qj = j; Qk = k; entry = t;
    imm = $urandom; pc = $urandom;
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    int nbusy;
    nbusy = 0;
    foreach (m[i]) nbusy += int'(m[i].busy);
    if (rst) begin
      check("full", 32'(full), 32'(nbusy == RS));
      model_edge(edge_cnt + 1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: consumes one prediction per DUT dispatch and flags missing ones.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (!rst) begin
        check("rst_valid", 32'(alu_valid), 32'd0);
      end else if (alu_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_dispatch", 32'(alu_valid), 32'd0);
        end else begin
          mon_d = exp_q.pop_front();
          check("disp_edge", 32'(edge_cnt), 32'(mon_d.stamp));
          check("disp_op", 32'(alu_op), 32'(mon_d.op));
          check("disp_a", alu_a, mon_d.a);
          check("disp_b", alu_b, mon_d.b);
          check("disp_imm", alu_imm, mon_d.imm);
          check("disp_pc", alu_pc, mon_d.pc);
          check("disp_tag", 32'(alu_tag), 32'(mon_d.tag));
        end
      end else if (exp_q.size() > 0 && exp_q[0].stamp <= edge_cnt) begin
        check("missed_dispatch", 32'(alu_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
`ifdef RS_OLDEST_FIRST_EN
    oldest_first = 1'b1;
`else
    oldest_first = 1'b0;
`endif
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_alu_valid", 32'(alu_valid), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_imm", alu_imm, 32'd0);
    check("rst_alu_pc", alu_pc, 32'd0);
    check("rst_alu_tag", 32'(alu_tag), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rst = 1'b1;

    // Ready issue: dispatch after the next edge, then alu_valid drops and fields hold.
    set_issue(6'd1, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
    tick(); idle(); tick();
    check("r017_valid", 32'(alu_valid), 32'd1);
    check("r017_op", 32'(alu_op), 32'd1);
    check("r017_a", alu_a, 32'd5);
    check("r017_b", alu_b, 32'd7);
    check("r017_tag", 32'(alu_tag), 32'd3);
    tick();
    check("r017_drop", 32'(alu_valid), 32'd0);
    check("r017_hold_a", alu_a, 32'd5);

    // Wake-up from LSB bus, then same-tag tie resolved in favour of the ALU bus.
    set_issue(6'd2, 32'd0, 32'd9, 4'd2, 4'd0, 4'd5);
    tick(); idle(); tick();
    check("r018_blocked", 32'(alu_valid), 32'd0);
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd2; cdb_lsb_val = 32'h10;
    tick(); idle();
    check("r018_wake_edge", 32'(alu_valid), 32'd0);
    tick();
    check("r018_valid", 32'(alu_valid), 32'd1);
    check("r018_a", alu_a, 32'h10);
    check("r018_b", alu_b, 32'd9);
    set_issue(6'd3, 32'd0, 32'd9, 4'd2, 4'd0, 4'd6);
    tick(); idle();
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd2; cdb_alu_val = 32'h20;
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd2; cdb_lsb_val = 32'h30;
    tick(); idle(); tick();
    check("r018_alu_wins", alu_a, 32'h20);

    // Issue-time forwarding.
    set_issue(6'd4, 32'd1, 32'd0, 4'd0, 4'd4, 4'd7);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd4; cdb_alu_val = 32'hAB;
    tick(); idle(); tick();
    check("r019_valid", 32'(alu_valid), 32'd1);
    check("r019_b", alu_b, 32'hAB);

    // Fill with blocked entries, ignored 9th issue, then drain on one broadcast.
    for (int i = 0; i < RS; i++) begin
      set_issue(6'd5, 32'(i), 32'(i), 4'd1, 4'd0, 4'(i + 2));
      tick();
    end
    idle();
    check("r020_full", 32'(full), 32'd1);
    set_issue(6'd6, 32'd1, 32'd1, 4'd0, 4'd0, 4'd15);
    tick(); idle();
    check("r020_still_full", 32'(full), 32'd1);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd1; cdb_alu_val = 32'h55;
    tick(); idle(); tick();
    check("r020_first_out", 32'(alu_valid), 32'd1);
    check("r020_first_tag", 32'(alu_tag), 32'd2);
    check("r020_not_full", 32'(full), 32'd0);
    repeat (8) tick();

    // Slot reuse: odd slots drain early and get refilled with younger instructions.
    for (int i = 0; i < RS; i++) begin
      set_issue(6'd7, 32'(100 + i), 32'(i), (i % 2 == 0) ? 4'd1 : 4'd2, 4'd0, 4'(i + 1));
      tick();
    end
    idle();
    cdb_lsb_valid = 1'b1; cdb_lsb_tag = 4'd2; cdb_lsb_val = 32'h77;
    tick(); idle(); tick();
    for (int i = 0; i < 4; i++) begin
      set_issue(6'd8, 32'(200 + i), 32'd0, 4'd1, 4'd0, 4'(9 + i));
      tick();
    end
    idle(); repeat (2) tick();
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd1; cdb_alu_val = 32'h99;
    tick(); idle(); tick();
    check("r020_reuse_first", 32'(alu_tag), 32'd1);
    tick();
    check("r020_reuse_second", 32'(alu_tag), oldest_first ? 32'd3 : 32'd9);
    repeat (8) tick();

    // Flush with rdy low frees everything and kills a valid dispatch.
    for (int i = 0; i < 3; i++) begin
      set_issue(6'd9, 32'(i), 32'(i), 4'd7, 4'd0, 4'(i + 1));
      tick();
    end
    set_issue(6'd10, 32'd1, 32'd2, 4'd0, 4'd0, 4'd4);
    tick(); idle(); tick();
    check("r021_pre_valid", 32'(alu_valid), 32'd1);
    clear = 1'b1; rdy = 1'b0;
    tick(); idle();
    check("r021_valid", 32'(alu_valid), 32'd0);
    check("r021_full", 32'(full), 32'd0);
    cdb_alu_valid = 1'b1; cdb_alu_tag = 4'd7; cdb_alu_val = 32'd1;
    tick(); idle(); repeat (3) tick();

    // Asynchronous reset while a dispatch is on the outputs.
    set_issue(6'd11, 32'h1234, 32'h5678, 4'd0, 4'd0, 4'd9);
    tick(); idle(); tick();
    check("arst_pre_valid", 32'(alu_valid), 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(alu_valid), 32'd0);
    check("arst_a", alu_a, 32'd0);
    check("arst_op", 32'(alu_op), 32'd0);
    check("arst_tag", 32'(alu_tag), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_issue(6'd12, 32'hCAFE, 32'd3, 4'd0, 4'd0, 4'd2);
    tick(); idle(); tick();
    check("arst_first_issue", 32'(alu_valid), 32'd1);
    check("arst_first_a", alu_a, 32'hCAFE);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rdy   = ($urandom_range(0, 7) != 0);
      clear = ($urandom_range(0, 99) == 0);
      is_rs = ($urandom_range(0, 2) != 0);
      op = 6'($urandom); Vj = $urandom; Vk = $urandom; imm = $urandom; pc = $urandom;
      Qj = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      Qk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
      entry = 4'($urandom_range(1, 15));
      cdb_alu_valid = ($urandom_range(0, 2) == 0);
      cdb_alu_tag = 4'($urandom_range(0, 3)); cdb_alu_val = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 2) == 0);
      cdb_lsb_tag = 4'($urandom_range(0, 3)); cdb_lsb_val = $urandom;
      tick();
    end
    idle();
    for (int n = 0; n < 30; n++) begin
      cdb_alu_valid = 1'b1; cdb_alu_tag = 4'((n % 3) + 1); cdb_alu_val = $urandom;
      tick();
    end
    idle(); repeat (3) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
